// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: divided pixel strobe, h/v counters,
// registered syncs/blanking, pixel coordinates, linear read address, line/frame strobes.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 11,
  parameter int   ADDR_W   = 19
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  output logic              pixel_ce,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic              video_active,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CE_W-1:0]  CE_LAST = CE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CE_W-1:0]   ce_cnt_q, ce_cnt_d;
  logic              run_q, run_d;
  logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pce_q, pce_d, hs_q, hs_d, vs_q, vs_d, act_q, act_d;
  logic              ls_q, ls_d, fs_q, fs_d;

  logic              tick, act_nxt, fs_nxt;
  logic [CNT_W-1:0]  h_nxt, v_nxt;

  always_comb begin
    tick = (ce_cnt_q == CE_LAST);

    // run_q=0 means idle: the first strobe lands on (0,0) instead of advancing.
    h_nxt = h_q;
    v_nxt = v_q;
    if (!run_q) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_q == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end else begin
      h_nxt = h_q + CNT_W'(1);
    end
    act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    fs_nxt  = (h_nxt == '0) && (v_nxt == '0);

    ce_cnt_d = tick ? '0 : ce_cnt_q + CE_W'(1);
    run_d    = run_q;
    h_d      = h_q;
    v_d      = v_q;
    addr_d   = addr_q;
    pce_d    = 1'b0;
    hs_d     = hs_q;
    vs_d     = vs_q;
    act_d    = act_q;
    ls_d     = 1'b0;
    fs_d     = 1'b0;

    if (enable) begin
      ce_cnt_d = '0;
      run_d    = 1'b0;
      h_d      = '0;
      v_d      = '0;
      addr_d   = '0;
      hs_d     = ~HS_POL;
      vs_d     = ~VS_POL;
      act_d    = 1'b0;
    end else if (tick) begin
      run_d  = 1'b1;
      h_d    = h_nxt;
      v_d    = v_nxt;
      pce_d  = 1'b1;
      act_d  = act_nxt;
      ls_d   = (h_nxt == '0);
      fs_d   = fs_nxt;
      hs_d   = (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_POL : ~HS_POL;
      vs_d   = (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_POL : ~VS_POL;
      // Address advances on entry to each active pixel, so it stops at the last one.
      if (fs_nxt)       addr_d = '0;
      else if (act_nxt) addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ce_cnt_q <= '0;
      run_q    <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      pce_q    <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      act_q    <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      run_q    <= run_d;
      h_q      <= h_d;
      v_q      <= v_d;
      addr_q   <= addr_d;
      pce_q    <= pce_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      act_q    <= act_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign pixel_ce     = pce_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign video_active = act_q;
  assign VGA_BLANK_N  = act_q;
  assign VGA_SYNC_N   = 1'b0;
  assign pixel_x      = h_q;
  assign pixel_y      = v_q;
  assign pixel_addr   = addr_q;
  assign line_start   = ls_q;
  assign frame_start  = fs_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator; successor to the fixed 640x480 sync chain.
- Runs from one system clock with an internal pixel-clock-enable divider.
- Sync widths, porches, active sizes and sync polarities are parameters.
- Besides the syncs it provides pixel coordinates, a linear frame-buffer read address, and line/frame strobes for the RAM/pixel pipeline downstream.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1); 1 = pixel_ce always high
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- HS_POL, 0, asserted level of VGA_HS
- VS_POL, 0, asserted level of VGA_VS
- CNT_W, 11, width of h/v counters and pixel_x/pixel_y
- ADDR_W, 19, width of pixel_addr

Ports:
- clock, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- enable, in, 1, active-low run enable; high = hold idle
- pixel_ce, out, 1, one-clock pixel strobe every CLK_DIV clocks
- VGA_HS, out, 1, horizontal sync, polarity HS_POL
- VGA_VS, out, 1, vertical sync, polarity VS_POL
- VGA_BLANK_N, out, 1, low outside the active region
- VGA_SYNC_N, out, 1, tied 0
- video_active, out, 1, high inside the active region
- pixel_x, out, CNT_W, horizontal position, 0..H_ACTIVE-1 when active
- pixel_y, out, CNT_W, vertical position, 0..V_ACTIVE-1 when active
- pixel_addr, out, ADDR_W, pixel_y*H_ACTIVE+pixel_x while active
- line_start, out, 1, pulse at h=0 of every line
- frame_start, out, 1, pulse at h=0, v=0

Behaviour:
- H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Line order is ACTIVE, FP, SYNC, BP. Frame order is the same.
- pixel_x equals h_cnt; pixel_y equals v_cnt.
- Divider: ce_cnt counts 0..CLK_DIV-1 and wraps; pixel_ce=1 when ce_cnt==CLK_DIV-1.
- h_cnt increments on pixel_ce and wraps H_TOTAL-1 -> 0.
- v_cnt increments when h_cnt wraps, and wraps V_TOTAL-1 -> 0. Simultaneous h and v wrap goes to (0,0).
- All outputs are registers updated in the same edge as the counters. Outputs always describe the current (h_cnt, v_cnt) with zero added latency.
- Horizontal sync is asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- Vertical sync is asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. VGA_VS transitions coincide with h_cnt=0.
- video_active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); VGA_BLANK_N = video_active.
- pixel_addr: cleared to 0 at frame_start; +1 on each pixel_ce while active; held outside the active region. No multiplier is used. The last active pixel holds V_ACTIVE*H_ACTIVE-1 (307199).
- line_start and frame_start are high for exactly one clock, on the pixel_ce-qualified edge that enters h_cnt=0 (and v_cnt=0 for frame_start).
- Reset (reset_n=0, any time, including mid-frame), asynchronous:
  - ce_cnt=0, h_cnt=0, v_cnt=0, pixel_addr=0
  - pixel_ce=0, video_active=0, VGA_BLANK_N=0
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL
  - line_start=0, frame_start=0
- enable=1 (synchronous): same values as reset, held every clock.
- On enable 1->0, the first pixel_ce occurs CLK_DIV clocks later. Counting starts at (0,0), and that first pixel_ce edge raises frame_start and line_start.
- Invariant: pixel_addr never exceeds H_ACTIVE*V_ACTIVE-1.

Test Plan:
- Defaults, CLK_DIV=2, release reset with enable=0:
  - pixel_ce period is 2 clocks
  - HS low for 96 pixels starting at h=656; line period 1600 clocks
- VS timing: VS low for exactly 2 lines starting at v=490; frame period 525 lines = 840000 clocks; frame_start once per frame.
- Address sweep:
  - pixel_addr=0 at the first active pixel; 639 at (639,0); 640 at (0,1)
  - 307199 at (639,479); holds through blanking
  - returns to 0 at the next frame_start
- Parameter/polarity check, H=8/1/2/1, V=4/1/1/1, CLK_DIV=1, HS_POL=1:
  - HS high at h=9..10; H_TOTAL=12
  - video_active counts 32 clocks per frame
- Mid-frame control, at (300,200):
  - assert reset_n=0 -> all outputs go to reset values immediately, without waiting for a clock
  - alternatively assert enable=1 -> outputs go to reset values on the next edge
  - release -> frame_start after CLK_DIV clocks
- Wrap boundary: at (799,524) the next pixel_ce gives (0,0) with line_start=frame_start=1 in the same clock and pixel_addr=0.
